// File: rtl/pc_gen_ras_if.sv
// pc_gen_ras_if: bus between ID/hazard logic and the IF-stage PC generator.
//   master : ID decode / hazard unit side (drives select, targets, stall)
//   slave  : pc_gen_ras (drives pc, RAS status, mispredict count)
// Exception signals (exc_req, exc_pc, eret, epc) exist only when
// PC_GEN_EXC_EN is defined.
interface pc_gen_ras_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4,
  parameter int CNT_W     = 8
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic [1:0]       pc_sel;
  logic             br_taken;
  logic             is_link;
  logic             rs_is_ra;
  logic [WIDTH-1:0] id_pc;
  logic [31:0]      instr;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] pc;
  logic             ras_mispred;
  logic [CW-1:0]    ras_cnt;
  logic [CNT_W-1:0] mis_cnt;
`ifdef PC_GEN_EXC_EN
  logic             exc_req;
  logic [WIDTH-1:0] exc_pc;
  logic             eret;
  logic [WIDTH-1:0] epc;
`endif

  modport master (
    output stall, pc_sel, br_taken, is_link, rs_is_ra, id_pc, instr, rs_val,
`ifdef PC_GEN_EXC_EN
    output exc_req, exc_pc, eret,
    input  epc,
`endif
    input  pc, ras_mispred, ras_cnt, mis_cnt
  );

  modport slave (
    input  stall, pc_sel, br_taken, is_link, rs_is_ra, id_pc, instr, rs_val,
`ifdef PC_GEN_EXC_EN
    input  exc_req, exc_pc, eret,
    output epc,
`endif
    output pc, ras_mispred, ras_cnt, mis_cnt
  );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_gen_ras: IF-stage PC register with next-PC select and a return-address
// stack that checks jr $ra targets.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : pc_gen_ras_if.slave
//     in  stall, pc_sel (00 seq, 01 br, 10 j, 11 jr), br_taken, is_link,
//         rs_is_ra, id_pc (PC+4 of ID instr), instr, rs_val
//     out pc, ras_mispred (1-cycle pulse), ras_cnt, mis_cnt (saturating)
// Optional: define PC_GEN_EXC_EN to add exc_req/exc_pc/eret inputs and the
// epc register. Priority there is exc_req > eret > stall > pc_sel.
// The RAS only checks; the PC always follows rs_val on jr.
module pc_gen_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
  parameter int               RAS_DEPTH = 4,
  parameter int               CNT_W     = 8,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180
) (
  input logic          clk,
  input logic          rst_n,
  pc_gen_ras_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] pc_q, next_pc, br_off;
  logic [PW-1:0]    ptr_q;    // next free slot; top of stack is ptr_q-1
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q;
  logic [CNT_W-1:0] mis_q;
  logic             mis_pulse_q;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic             redirect_ovr, push, pop, mispred_nxt;
  logic             unused_instr;

  assign unused_instr = ^bus.instr[31:26];

`ifdef PC_GEN_EXC_EN
  logic [WIDTH-1:0] epc_q;
  assign redirect_ovr = bus.exc_req | bus.eret;
  assign bus.epc      = epc_q;
`else
  assign redirect_ovr = 1'b0;
`endif

  assign br_off  = {{(WIDTH-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign top_idx = ptr_q - 1'b1;

  always_comb begin
    next_pc = pc_q + WIDTH'(4);
    unique case (bus.pc_sel)
      2'b00: next_pc = pc_q + WIDTH'(4);
      2'b01: next_pc = bus.br_taken ? bus.id_pc + br_off : pc_q + WIDTH'(4);
      2'b10: next_pc = {bus.id_pc[WIDTH-1:28], bus.instr[25:0], 2'b00};
      2'b11: next_pc = bus.rs_val;
    endcase
  end

  // Exceptions/eret and stalls both suppress stack activity.
  assign push = !redirect_ovr && !bus.stall && bus.pc_sel == 2'b10 && bus.is_link;
  assign pop  = !redirect_ovr && !bus.stall && bus.pc_sel == 2'b11 && bus.rs_is_ra;
  assign mispred_nxt = pop && (cnt_q == '0 || ras[top_idx] != bus.rs_val);

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
`ifdef PC_GEN_EXC_EN
      epc_q <= '0;
`endif
    end else begin
`ifdef PC_GEN_EXC_EN
      if (bus.exc_req) begin
        pc_q  <= EXC_VEC;
        epc_q <= bus.exc_pc;
      end else if (bus.eret) begin
        pc_q <= epc_q;
      end else
`endif
      if (!bus.stall) pc_q <= next_pc;
    end
  end

  // Stack pointer, occupancy and mispredict tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      mis_pulse_q <= 1'b0;
      mis_q       <= '0;
    end else begin
      mis_pulse_q <= mispred_nxt;
      if (mispred_nxt && mis_q != '1) mis_q <= mis_q + 1'b1;
      if (push) begin
        // Full stack wraps over the oldest entry; count pins at depth.
        ptr_q <= ptr_q + 1'b1;
        if (cnt_q != CW'(RAS_DEPTH)) cnt_q <= cnt_q + 1'b1;
      end else if (pop && cnt_q != '0) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Stack storage needs no reset: entries are only read while cnt_q > 0.
  always_ff @(posedge clk) begin
    if (push) ras[ptr_q] <= bus.id_pc;
  end

  assign bus.pc          = pc_q;
  assign bus.ras_mispred = mis_pulse_q;
  assign bus.ras_cnt     = cnt_q;
  assign bus.mis_cnt     = mis_q;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed bench for pc_gen_ras (exception steps only with PC_GEN_EXC_EN).
module tb_pc_gen_ras;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_gen_ras_if #(.WIDTH(32), .RAS_DEPTH(4), .CNT_W(8)) bus ();
  pc_gen_ras dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] sel, input logic link, input logic ra,
                        input logic [31:0] idpc, input logic [31:0] rsv);
    bus.pc_sel = sel; bus.is_link = link; bus.rs_is_ra = ra;
    bus.id_pc = idpc; bus.rs_val = rsv;
  endtask

  initial begin
    logic [31:0] pops [4];
    bus.stall = 0; bus.pc_sel = 2'b00; bus.br_taken = 0; bus.is_link = 0;
    bus.rs_is_ra = 0; bus.id_pc = '0; bus.instr = '0; bus.rs_val = '0;
`ifdef PC_GEN_EXC_EN
    bus.exc_req = 0; bus.exc_pc = '0; bus.eret = 0;
`endif
    #12;
    chk("rst_pc", bus.pc, 32'h3000);
    chk("rst_cnt", 32'(bus.ras_cnt), 0);
    chk("rst_mis", 32'(bus.mis_cnt), 0);
    chk("rst_pulse", 32'(bus.ras_mispred), 0);
    @(negedge clk); rst_n = 1;

    // 1: sequential fetch
    step(); chk("seq1", bus.pc, 32'h3004);
    step(); chk("seq2", bus.pc, 32'h3008);
    step(); chk("seq3", bus.pc, 32'h300C);

    // 2: branch taken backward (3010 - 8), then not taken
    bus.instr = 32'h0000_FFFE; bus.br_taken = 1;
    set_in(2'b01, 0, 0, 32'h3010, 0);
    step(); chk("br_taken", bus.pc, 32'h3008);
    bus.br_taken = 0;
    step(); chk("br_not", bus.pc, 32'h300C);

    // 3: jal push, matching jr $ra, then mismatching jr $ra
    bus.instr = 32'h0000_0C10;             // jump target 3040
    set_in(2'b10, 1, 0, 32'h3024, 0);
    step(); chk("jal_pc", bus.pc, 32'h3040); chk("jal_cnt", 32'(bus.ras_cnt), 1);
    set_in(2'b11, 0, 1, 0, 32'h3024);
    step(); chk("jr_pc", bus.pc, 32'h3024); chk("jr_pulse", 32'(bus.ras_mispred), 0);
    chk("jr_cnt", 32'(bus.ras_cnt), 0);
    set_in(2'b10, 1, 0, 32'h3024, 0);
    step(); chk("jal2_cnt", 32'(bus.ras_cnt), 1);
    set_in(2'b11, 0, 1, 0, 32'h3030);
    step(); chk("jr_bad_pulse", 32'(bus.ras_mispred), 1); chk("jr_bad_mis", 32'(bus.mis_cnt), 1);
    chk("jr_bad_pc", bus.pc, 32'h3030);
    set_in(2'b00, 1, 1, 0, 0);             // link/ra ignored on seq
    step(); chk("pulse_drop", 32'(bus.ras_mispred), 0); chk("ign_cnt", 32'(bus.ras_cnt), 0);

    // 4: overfill the stack, then drain it past empty
    for (int i = 0; i < 5; i++) begin
      set_in(2'b10, 1, 0, 32'h100 + 32'(4*i), 0);
      step(); chk("push_cnt", 32'(bus.ras_cnt), (i < 4) ? 32'(i + 1) : 32'd4);
    end
    pops = '{32'h110, 32'h10C, 32'h108, 32'h104};
    for (int i = 0; i < 4; i++) begin
      set_in(2'b11, 0, 1, 0, pops[i]);
      step(); chk("pop_pulse", 32'(bus.ras_mispred), 0);
      chk("pop_cnt", 32'(bus.ras_cnt), 32'(3 - i));
    end
    set_in(2'b11, 0, 1, 0, 32'h500);
    step(); chk("empty_pulse", 32'(bus.ras_mispred), 1); chk("empty_cnt", 32'(bus.ras_cnt), 0);
    chk("empty_mis", 32'(bus.mis_cnt), 2); chk("empty_pc", bus.pc, 32'h500);

    // 5: stalled jal holds PC and stack; release applies it once
    bus.stall = 1; set_in(2'b10, 1, 0, 32'h200, 0);
    step(); chk("stall_pc", bus.pc, 32'h500); chk("stall_cnt", 32'(bus.ras_cnt), 0);
    step(); chk("stall_pc2", bus.pc, 32'h500);
    bus.stall = 0;
    step(); chk("unstall_pc", bus.pc, 32'h3040); chk("unstall_cnt", 32'(bus.ras_cnt), 1);
    set_in(2'b00, 0, 0, 0, 0);
    step(); chk("after_cnt", 32'(bus.ras_cnt), 1); chk("after_pc", bus.pc, 32'h3044);

    // stalled jr $ra: no pop, no pulse
    bus.stall = 1; set_in(2'b11, 0, 1, 0, 32'h999);
    step(); chk("stall_jr_pulse", 32'(bus.ras_mispred), 0); chk("stall_jr_cnt", 32'(bus.ras_cnt), 1);
    bus.stall = 0;

    // mispredict counter saturation (stack top 200 mismatches, then empty)
    set_in(2'b11, 0, 1, 0, 32'h600);
    for (int i = 0; i < 260; i++) step();
    chk("mis_sat", 32'(bus.mis_cnt), 32'hFF);
    chk("sat_pulse", 32'(bus.ras_mispred), 1);

`ifdef PC_GEN_EXC_EN
    // 6: exception overrides stall, eret returns
    bus.stall = 1; bus.exc_req = 1; bus.exc_pc = 32'h3040;
    step(); chk("exc_pc", bus.pc, 32'h4180); chk("exc_epc", bus.epc, 32'h3040);
    chk("exc_pulse", 32'(bus.ras_mispred), 0);
    bus.exc_req = 0; bus.eret = 1;
    step(); chk("eret_pc", bus.pc, 32'h3040);
    bus.eret = 0; bus.stall = 0;
`endif

    // asynchronous reset mid-cycle
    set_in(2'b10, 1, 0, 32'h300, 0);
    step();
    #2 rst_n = 0; #1;
    chk("arst_pc", bus.pc, 32'h3000); chk("arst_cnt", 32'(bus.ras_cnt), 0);
    chk("arst_mis", 32'(bus.mis_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
